load_store_unit: RTL and testbench

Sits between the single-cycle datapath and `data_memory`. It turns byte-addressed load/store requests into word-indexed memory accesses:
- extracts and extends byte or halfword loads;
- performs byte and halfword stores as read-modify-write;
- flags misaligned accesses.

It stalls the CPU with `stall` while the multi-cycle sequence runs, so the PC and request stay frozen until `done`.

---
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte-addressed load/store requests from the datapath
// into word-indexed data_memory accesses. Sub-word loads are extracted and
// extended, sub-word stores are done as read-modify-write, and misaligned or
// reserved-size requests are rejected with an error pulse.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for req_valid; request is latched when it arrives
// RD    | mem_read asserted; load result or merged store word registered
// WR    | mem_write asserted for exactly this cycle
// DONE  | done pulse, back to IDLE
// ERR   | done + misaligned pulse, no memory access, back to IDLE
module load_store_unit #(
    parameter int size   = 32,
    parameter int length = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [1:0]                 req_size,
    input  logic                       req_signed,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       stall,
    output logic                       done,
    output logic [31:0]                load_data,
    output logic                       misaligned,
    output logic [$clog2(length)-1:0]  mem_address,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [size-1:0]            mem_wdata,
    input  logic [size-1:0]            mem_rdata
);
    localparam int aw = $clog2(length);

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

    state_t          state;
    logic [aw+1:0]   addr_q;
    logic [1:0]      size_q;
    logic            signed_q;
    logic            write_q;
    logic [15:0]     wdata_q;

    logic            req_mis;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;
    logic [size-1:0] merged;

    // Address bits above the memory index are ignored so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:aw+2];

    // Reject halfwords on odd bytes, words off a word boundary, and size 11.
    assign req_mis = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));

    // Little-endian lane select and extension of the word read from memory.
    always_comb begin
        rd_byte  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_val = mem_rdata;
        case (size_q)
            2'b00:   load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_val = mem_rdata;
        endcase
    end

    // Store merge: only the addressed lane takes the new data.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (size_q == 2'b01)
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Sequencer: captures the request, walks RD/WR, and registers results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            load_data <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr[aw+1:0];
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        wdata_q  <= req_wdata[15:0];
                        if (req_mis) begin
                            state <= ERR;
                        end else if (req_write && req_size == 2'b10) begin
                            mem_wdata <= req_wdata;
                            state     <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        mem_wdata <= merged;
                        state     <= WR;
                    end else begin
                        load_data <= load_val;
                        state     <= DONE;
                    end
                end
                WR:      state <= DONE;
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes come straight from the state register so reset kills them at once.
    assign mem_read    = (state == RD);
    assign mem_write   = (state == WR);
    assign done        = (state == DONE) | (state == ERR);
    assign misaligned  = (state == ERR);
    assign stall       = ((state == IDLE) & req_valid) | (state == RD) | (state == WR);
    assign mem_address = addr_q[aw+1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data_memory, scoreboard of expected
// completions, one task per scenario.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misaligned, mem_read, mem_write;
    logic [31:0] load_data, mem_wdata, mem_rdata;
    logic [7:0]  mem_address;

    logic [31:0] mem [256];

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          lat;
        logic        chk_data;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    int          obs_cyc;
    logic [31:0] obs_data;
    logic        obs_mis;
    logic [7:0]  obs_stall, obs_rd, obs_wr;
    logic [31:0] obs_wdata;
    logic [7:0]  obs_waddr;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address];
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_wdata;

    load_store_unit #(.size(32), .length(256)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .done(done), .load_data(load_data),
        .misaligned(misaligned), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] sz, logic sg, logic [31:0] a);
        logic [31:0] sh;
        sh = w >> (8 * a[1:0]);
        if (sz == 2'b00) return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        if (sz == 2'b01) return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] w, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        logic [31:0] m;
        m = (sz == 2'b00) ? (32'hFF << (8 * a[1:0])) : (32'hFFFF << (16 * a[1]));
        return (w & ~m) | ((d << (8 * a[1:0])) & m);
    endfunction

    // Called at posedge+1 with the DUT idle; drives one request, records what it sees.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        obs_stall = '0; obs_rd = '0; obs_wr = '0;
        obs_cyc = -1; obs_wdata = '0; obs_waddr = '0;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs_stall[c] = stall;
            obs_rd[c]    = mem_read;
            obs_wr[c]    = mem_write;
            if (mem_write) begin
                obs_wdata = mem_wdata;
                obs_waddr = mem_address;
            end
            if (done) begin
                obs_cyc  = c;
                obs_data = load_data;
                obs_mis  = misaligned;
                got = 1;
                break;
            end
            @(posedge clk);
        end
        if (!got) begin
            total++;
            $display("FAIL timeout: no done within 8 cycles (addr %h)", a);
            $fatal(1, "FAIL timeout");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        mem[4] = 32'h8899AABB;
    endtask

    task automatic test_reset();
        req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        reset = 1'b1;
        #12;
        total++; if (done !== 1'b0)          $display("FAIL rst_done got %b exp 0", done); else passed++;
        total++; if (misaligned !== 1'b0)    $display("FAIL rst_mis got %b exp 0", misaligned); else passed++;
        total++; if (load_data !== 32'h0)    $display("FAIL rst_load_data got %h exp 0", load_data); else passed++;
        total++; if (mem_read !== 1'b0)      $display("FAIL rst_mem_read got %b exp 0", mem_read); else passed++;
        total++; if (mem_write !== 1'b0)     $display("FAIL rst_mem_write got %b exp 0", mem_write); else passed++;
        total++; if (mem_wdata !== 32'h0)    $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); else passed++;
        total++; if (mem_address !== 8'h0)   $display("FAIL rst_mem_address got %h exp 0", mem_address); else passed++;
        total++; if (stall !== 1'b0)         $display("FAIL rst_stall got %b exp 0", stall); else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_signed_byte();
        preload();
        sb_q.push_back('{data: 32'hFFFFFF88, mis: 1'b0, lat: 2, chk_data: 1'b1});
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_cyc !== e.lat)    $display("FAIL lb_latency got %0d exp %0d", obs_cyc, e.lat); else passed++;
        total++; if (obs_data !== e.data)  $display("FAIL lb_data got %h exp %h", obs_data, e.data); else passed++;
        total++; if (obs_stall !== 8'h03)  $display("FAIL lb_stall_cycles got %b exp 00000011", obs_stall); else passed++;
        total++; if (obs_wr !== 8'h00)     $display("FAIL lb_no_write got %b exp 0", obs_wr); else passed++;
        total++; if (obs_rd !== 8'h02)     $display("FAIL lb_read_cycle got %b exp 00000010", obs_rd); else passed++;
    endtask

    task automatic test_load_half();
        preload();
        sb_q.push_back('{data: 32'h00008899, mis: 1'b0, lat: 2, chk_data: 1'b1});
        run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_data !== e.data) $display("FAIL lhu_data got %h exp %h", obs_data, e.data); else passed++;
        total++; if (obs_cyc !== e.lat)   $display("FAIL lhu_latency got %0d exp %0d", obs_cyc, e.lat); else passed++;
        sb_q.push_back('{data: 32'hFFFF8899, mis: 1'b0, lat: 2, chk_data: 1'b1});
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_data !== e.data) $display("FAIL lh_data got %h exp %h", obs_data, e.data); else passed++;
        total++; if (obs_mis !== e.mis)   $display("FAIL lh_mis got %b exp %b", obs_mis, e.mis); else passed++;
    endtask

    task automatic test_store_byte();
        preload();
        sb_q.push_back('{data: 32'h88995CBB, mis: 1'b0, lat: 3, chk_data: 1'b0});
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005C);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_cyc !== e.lat)     $display("FAIL sb_latency got %0d exp %0d", obs_cyc, e.lat); else passed++;
        total++; if (obs_rd !== 8'h02)      $display("FAIL sb_read_cycle got %b exp 00000010", obs_rd); else passed++;
        total++; if (obs_wr !== 8'h04)      $display("FAIL sb_write_cycle got %b exp 00000100", obs_wr); else passed++;
        total++; if (obs_wdata !== e.data)  $display("FAIL sb_wdata got %h exp %h", obs_wdata, e.data); else passed++;
        total++; if (obs_waddr !== 8'd4)    $display("FAIL sb_address got %h exp 04", obs_waddr); else passed++;
        total++; if (mem[4] !== e.data)     $display("FAIL sb_mem_word got %h exp %h", mem[4], e.data); else passed++;
    endtask

    task automatic test_back_to_back();
        preload();
        sb_q.push_back('{data: 32'hDEADBEEF, mis: 1'b0, lat: 2, chk_data: 1'b0});
        run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
        e = sb_q.pop_front();
        total++; if (obs_wr !== 8'h02)      $display("FAIL sw_write_cycle got %b exp 00000010", obs_wr); else passed++;
        total++; if (obs_cyc !== e.lat)     $display("FAIL sw_latency got %0d exp %0d", obs_cyc, e.lat); else passed++;
        total++; if (obs_wdata !== e.data)  $display("FAIL sw_wdata got %h exp %h", obs_wdata, e.data); else passed++;
        total++; if (obs_rd !== 8'h00)      $display("FAIL sw_no_read got %b exp 0", obs_rd); else passed++;
        // req_valid stays high: next request is taken in the idle cycle after done
        sb_q.push_back('{data: 32'hDEADBEEF, mis: 1'b0, lat: 2, chk_data: 1'b1});
        run_req(1'b0, 2'b10, 1'b1, 32'h14, 32'h0);
        e = sb_q.pop_front();
        total++; if (obs_data !== e.data)   $display("FAIL lw_data got %h exp %h", obs_data, e.data); else passed++;
        sb_q.push_back('{data: 32'h8899AABB, mis: 1'b0, lat: 2, chk_data: 1'b1});
        run_req(1'b0, 2'b10, 1'b0, 32'h410, 32'h0);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_data !== e.data)   $display("FAIL lw_wrap_data got %h exp %h", obs_data, e.data); else passed++;
    endtask

    task automatic test_misaligned();
        preload();
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        idle_gap();
        sb_q.push_back('{data: 32'h8899AABB, mis: 1'b1, lat: 1, chk_data: 1'b1});
        run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_cyc !== e.lat)    $display("FAIL mis_latency got %0d exp %0d", obs_cyc, e.lat); else passed++;
        total++; if (obs_mis !== e.mis)    $display("FAIL mis_flag got %b exp %b", obs_mis, e.mis); else passed++;
        total++; if ((obs_rd | obs_wr) !== 8'h00) $display("FAIL mis_no_access got %b exp 0", obs_rd | obs_wr); else passed++;
        total++; if (obs_data !== e.data)  $display("FAIL mis_load_kept got %h exp %h", obs_data, e.data); else passed++;
        total++; if (obs_stall !== 8'h01)  $display("FAIL mis_stall got %b exp 00000001", obs_stall); else passed++;
        sb_q.push_back('{data: 32'h8899AABB, mis: 1'b1, lat: 1, chk_data: 1'b1});
        run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_cyc !== e.lat)    $display("FAIL rsv_latency got %0d exp %0d", obs_cyc, e.lat); else passed++;
        total++; if (obs_mis !== e.mis)    $display("FAIL rsv_flag got %b exp %b", obs_mis, e.mis); else passed++;
        total++; if ((obs_rd | obs_wr) !== 8'h00) $display("FAIL rsv_no_access got %b exp 0", obs_rd | obs_wr); else passed++;
        total++; if (mem[4] !== 32'h8899AABB) $display("FAIL rsv_mem_kept got %h exp 8899aabb", mem[4]); else passed++;
        // halfword on an odd byte
        sb_q.push_back('{data: 32'h8899AABB, mis: 1'b1, lat: 1, chk_data: 1'b1});
        run_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
        idle_gap();
        e = sb_q.pop_front();
        total++; if (obs_mis !== e.mis)    $display("FAIL mis_half_flag got %b exp %b", obs_mis, e.mis); else passed++;
    endtask

    task automatic test_random_ops();
        logic [31:0] ref_mem [8];
        logic [31:0] a, d, x;
        logic [1:0]  sz;
        logic        sg;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            mem[i] = ref_mem[i];
        end
        for (int i = 0; i < 12; i++) begin
            sz = 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            a  = {24'h0, 3'($urandom_range(0, 7)), 2'b00};
            if (sz == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == 2'b01) a[1]   = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (i % 2 == 0) begin
                x = ref_load(ref_mem[a[4:2]], sz, sg, a);
                sb_q.push_back('{data: x, mis: 1'b0, lat: 2, chk_data: 1'b1});
                run_req(1'b0, sz, sg, a, 32'h0);
                idle_gap();
                e = sb_q.pop_front();
                total++; if (obs_data !== e.data) $display("FAIL rnd_load[%0d] got %h exp %h", i, obs_data, e.data); else passed++;
            end else begin
                x = (sz == 2'b10) ? d : ref_merge(ref_mem[a[4:2]], sz, a, d);
                ref_mem[a[4:2]] = x;
                sb_q.push_back('{data: x, mis: 1'b0, lat: (sz == 2'b10) ? 2 : 3, chk_data: 1'b0});
                run_req(1'b1, sz, sg, a, d);
                idle_gap();
                e = sb_q.pop_front();
                total++; if (obs_wdata !== e.data) $display("FAIL rnd_store[%0d] got %h exp %h", i, obs_wdata, e.data); else passed++;
                total++; if (obs_cyc !== e.lat)    $display("FAIL rnd_store_lat[%0d] got %0d exp %0d", i, obs_cyc, e.lat); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_store();
        preload();
        req_valid = 1; req_write = 1; req_size = 2'b01; req_signed = 0;
        req_addr = 32'h10; req_wdata = 32'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (mem_write !== 1'b1) $display("FAIL rstwr_in_wr got %b exp 1", mem_write); else passed++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (mem_write !== 1'b0)     $display("FAIL rstwr_write_drop got %b exp 0", mem_write); else passed++;
        total++; if (mem_wdata !== 32'h0)    $display("FAIL rstwr_wdata got %h exp 0", mem_wdata); else passed++;
        total++; if (mem_address !== 8'h0)  $display("FAIL rstwr_address got %h exp 0", mem_address); else passed++;
        total++; if (done !== 1'b0)          $display("FAIL rstwr_done got %b exp 0", done); else passed++;
        total++; if (load_data !== 32'h0)    $display("FAIL rstwr_load_data got %h exp 0", load_data); else passed++;
        @(posedge clk); #1;
        req_valid = 0;
        #1;
        total++; if (stall !== 1'b0)         $display("FAIL rstwr_stall got %b exp 0", stall); else passed++;
        total++; if (mem[4] !== 32'h8899AABB) $display("FAIL rstwr_mem_kept got %h exp 8899aabb", mem[4]); else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_load_signed_byte();
        test_load_half();
        test_store_byte();
        test_back_to_back();
        test_misaligned();
        test_random_ops();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "FAIL global_timeout");
    end

endmodule
